// File: rtl/seq_word_serializer.sv
// Parallel-to-serial word stage driving the 101-detector input 'w', with valid/ready intake and back-to-back frames.
// Optional `SEQ_PARITY_EN appends one even-parity bit to every frame.
module seq_word_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             w,
    output logic             w_valid,
    output logic             frame_done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

`ifdef SEQ_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic             w_n, w_valid_n, frame_done_n;
    logic             last_cycle, accept;
    logic             din_head, sreg_head;
    logic [WIDTH-1:0] din_rest, sreg_rest;

`ifdef SEQ_PARITY_EN
    logic             par, par_n;
`endif

    // sreg always holds the not-yet-sent bits aligned so the next one sits at the head
    assign din_head  = MSB_FIRST ? din[WIDTH-1]  : din[0];
    assign sreg_head = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    assign din_rest  = MSB_FIRST ? {din[WIDTH-2:0], 1'b0}  : {1'b0, din[WIDTH-1:1]};
    assign sreg_rest = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

`ifdef SEQ_PARITY_EN
    assign last_cycle = (state == PARITY);
`else
    assign last_cycle = (state == SHIFT) && (cnt == '0);
`endif

    assign din_ready = (state == IDLE) || last_cycle;
    assign accept    = din_valid && din_ready;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            sreg       <= '0;
            w          <= 1'b0;
            w_valid    <= 1'b0;
            frame_done <= 1'b0;
`ifdef SEQ_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sreg       <= sreg_n;
            w          <= w_n;
            w_valid    <= w_valid_n;
            frame_done <= frame_done_n;
`ifdef SEQ_PARITY_EN
            par        <= par_n;
`endif
        end
    end

    // An accept takes priority so a word offered in the last frame cycle follows with no gap
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        sreg_n       = sreg;
        w_n          = 1'b0;
        w_valid_n    = 1'b0;
        frame_done_n = 1'b0;
`ifdef SEQ_PARITY_EN
        par_n        = par;
`endif
        if (accept) begin
            state_n   = SHIFT;
            cnt_n     = CNT_LAST;
            sreg_n    = din_rest;
            w_n       = din_head;
            w_valid_n = 1'b1;
`ifdef SEQ_PARITY_EN
            par_n     = ^din;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state_n = IDLE;
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        cnt_n     = cnt - CW'(1);
                        sreg_n    = sreg_rest;
                        w_n       = sreg_head;
                        w_valid_n = 1'b1;
`ifndef SEQ_PARITY_EN
                        frame_done_n = (cnt == CW'(1));
`endif
                    end else begin
`ifdef SEQ_PARITY_EN
                        state_n      = PARITY;
                        w_n          = par;
                        w_valid_n    = 1'b1;
                        frame_done_n = 1'b1;
`else
                        state_n      = IDLE;
`endif
                    end
                end
`ifdef SEQ_PARITY_EN
                PARITY: begin
                    state_n = IDLE;
                end
`endif
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_word_serializer.sv
// Randomised self-checking bench for seq_word_serializer; an MSB-first and an LSB-first instance run side by side
// against a per-cycle stream model built from word bits (plus parity when SEQ_PARITY_EN is defined).
module tb_seq_word_serializer;

    localparam int WIDTH = 8;
`ifdef SEQ_PARITY_EN
    localparam int L = WIDTH + 1;
`else
    localparam int L = WIDTH;
`endif

    typedef logic [7:0] sample_t;

    logic             Clk;
    logic             Reset;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready, w, w_valid, frame_done;
    logic             l_din_ready, l_w, l_w_valid, l_frame_done;

    int checks;
    int passed;

    sample_t obs[$];
    sample_t expq[$];

    localparam sample_t IDLE_SAMPLE = 8'b0001_0001;

    seq_word_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut (
        .Clk(Clk), .Reset(Reset), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .w(w), .w_valid(w_valid), .frame_done(frame_done)
    );

    seq_word_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
        .Clk(Clk), .Reset(Reset), .din(din), .din_valid(din_valid),
        .din_ready(l_din_ready), .w(l_w), .w_valid(l_w_valid), .frame_done(l_frame_done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic sample_t observe();
        return {w, w_valid, frame_done, din_ready, l_w, l_w_valid, l_frame_done, l_din_ready};
    endfunction

    // Frame bit i of a word: data bits in the chosen order, then the even parity bit
    function automatic logic ref_bit(logic [7:0] word, int i, bit msb_first);
        if (i >= WIDTH) return ^word;
        return msb_first ? word[WIDTH-1-i] : word[i];
    endfunction

    function automatic sample_t exp_sample(logic [7:0] word, int i);
        logic last;
        last = (i == L - 1);
        return {ref_bit(word, i, 1'b1), 1'b1, last, last, ref_bit(word, i, 1'b0), 1'b1, last, last};
    endfunction

    task automatic build_expected(input logic [7:0] words [8], input int n);
        expq.delete();
        for (int f = 0; f < n; f++)
            for (int i = 0; i < L; i++)
                expq.push_back(exp_sample(words[f], i));
        expq.push_back(IDLE_SAMPLE);
    endtask

    // Offers each next word as soon as the previous one is taken and holds it until accepted
    task automatic applyStimulus(input logic [7:0] words [8], input int n);
        obs.delete();
        din       = words[0];
        din_valid = 1'b1;
        for (int k = 0; k <= n * L; k++) begin
            @(posedge Clk);
            #1;
            obs.push_back(observe());
            if ((k % L) == 0 && k < n * L) begin
                if (k / L + 1 < n) begin
                    din = words[k / L + 1];
                end else begin
                    din_valid = 1'b0;
                    din       = 8'($urandom);
                end
            end
        end
    endtask

    task automatic test_reset();
        Reset     = 1'b0;
        din_valid = 1'b1;
        din       = 8'hA5;
        #1;
        checks++;
        if (observe() !== IDLE_SAMPLE)
            $display("[TB] FAIL reset_async: got %b required %b", observe(), IDLE_SAMPLE);
        else passed++;
        for (int c = 0; c < 3; c++) begin
            @(posedge Clk);
            #1;
            checks++;
            if (observe() !== IDLE_SAMPLE)
                $display("[TB] FAIL reset_hold cycle %0d: got %b required %b", c, observe(), IDLE_SAMPLE);
            else passed++;
        end
        din_valid = 1'b0;
        Reset     = 1'b1;
        @(posedge Clk);
        #1;
        checks++;
        if (observe() !== IDLE_SAMPLE)
            $display("[TB] FAIL reset_release_idle: got %b required %b", observe(), IDLE_SAMPLE);
        else passed++;
    endtask

    task automatic test_single_word();
        logic [7:0] wl [8];
        wl = '{default: 8'h00};
        wl[0] = 8'hA5;
        applyStimulus(wl, 1);
        build_expected(wl, 1);
        for (int k = 0; k < expq.size(); k++) begin
            checks++;
            if (obs[k] !== expq[k])
                $display("[TB] FAIL single_A5 cycle %0d: got %b required %b", k, obs[k], expq[k]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] wl [8];
        wl = '{default: 8'h00};
        wl[0] = 8'hFF;
        wl[1] = 8'h00;
        applyStimulus(wl, 2);
        build_expected(wl, 2);
        for (int k = 0; k < expq.size(); k++) begin
            checks++;
            if (obs[k] !== expq[k])
                $display("[TB] FAIL b2b_FF_00 cycle %0d: got %b required %b", k, obs[k], expq[k]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] wl [8];
        din       = 8'hC3;
        din_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge Clk);
            #1;
            din_valid = 1'b0;
            checks++;
            if (observe() !== exp_sample(8'hC3, k))
                $display("[TB] FAIL abort_C3 bit %0d: got %b required %b", k, observe(), exp_sample(8'hC3, k));
            else passed++;
        end
        #3;
        Reset = 1'b0;
        #1;
        checks++;
        if (observe() !== IDLE_SAMPLE)
            $display("[TB] FAIL abort_async_drop: got %b required %b", observe(), IDLE_SAMPLE);
        else passed++;
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        checks++;
        if (observe() !== IDLE_SAMPLE)
            $display("[TB] FAIL abort_no_resume: got %b required %b", observe(), IDLE_SAMPLE);
        else passed++;
        wl = '{default: 8'h00};
        wl[0] = 8'h81;
        applyStimulus(wl, 1);
        build_expected(wl, 1);
        for (int k = 0; k < expq.size(); k++) begin
            checks++;
            if (obs[k] !== expq[k])
                $display("[TB] FAIL after_abort_81 cycle %0d: got %b required %b", k, obs[k], expq[k]);
            else passed++;
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] wl [8];
        wl = '{default: 8'h00};
        wl[0] = 8'h01;
        applyStimulus(wl, 1);
        build_expected(wl, 1);
        for (int k = 0; k < expq.size(); k++) begin
            checks++;
            if (obs[k] !== expq[k])
                $display("[TB] FAIL order_01 cycle %0d: got %b required %b", k, obs[k], expq[k]);
            else passed++;
        end
    endtask

    task automatic test_parity_words();
        logic [7:0] wl [8];
        wl = '{default: 8'h00};
        wl[0] = 8'h07;
        wl[1] = 8'h03;
        applyStimulus(wl, 2);
        build_expected(wl, 2);
        for (int k = 0; k < expq.size(); k++) begin
            checks++;
            if (obs[k] !== expq[k])
                $display("[TB] FAIL parity_07_03 cycle %0d: got %b required %b", k, obs[k], expq[k]);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [7:0] wl [8];
        int n;
        for (int it = 0; it < 8; it++) begin
            n = int'($urandom_range(1, 3));
            for (int j = 0; j < 8; j++) wl[j] = 8'($urandom);
            applyStimulus(wl, n);
            build_expected(wl, n);
            for (int k = 0; k < expq.size(); k++) begin
                checks++;
                if (obs[k] !== expq[k])
                    $display("[TB] FAIL random_%0d cycle %0d: got %b required %b", it, k, obs[k], expq[k]);
                else passed++;
            end
            repeat ($urandom_range(0, 2)) @(posedge Clk);
            #1;
        end
    endtask

    initial begin
        checks    = 0;
        passed    = 0;
        Reset     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_reset_mid_frame();
        test_lsb_first();
        test_parity_words();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
